eq_compare_arbiter: RTL and testbench

//  Shares one 4-bit equality_comp instance (ports A, B, is_equal) among N_REQ requesters.

---
 rtl/eq_compare_arbiter.sv | 156 +++++++++++++++
 tb/tb_eq_compare_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/eq_compare_arbiter.sv
// Round-robin arbiter sharing one 4-bit equality comparator among N_REQ requesters.
// Optional saturating match counter on hit_cnt is built when EQ_HIT_COUNT_EN is defined.

module equality_comp (
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic       is_equal
);
   assign is_equal = (A == B);
endmodule

module eq_compare_arbiter #(
   parameter int N_REQ = 2,
   parameter int ID_W  = 1,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [4*N_REQ-1:0] req_a,
   input  logic [4*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
`ifdef EQ_HIT_COUNT_EN
   output logic               rsp_equal,
   output logic [CNT_W-1:0]   hit_cnt
`else
   output logic               rsp_equal
`endif
);

   localparam int SW = ID_W + 1;
   localparam logic [SW-1:0] N_L = SW'(N_REQ);

   generate
      if (N_REQ < 2 || N_REQ > 4 || ID_W != $clog2(N_REQ) || CNT_W < 1) begin : g_bad_params
         $error("eq_compare_arbiter: illegal parameter combination");
      end
   endgenerate

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_reg, state_next;
   logic [ID_W-1:0] rr_ptr_reg;
   logic [ID_W-1:0] rsp_id_reg;
   logic [3:0]      op_a_reg, op_b_reg;
   logic            is_equal;

   logic [3:0]      a_arr    [N_REQ];
   logic [3:0]      b_arr    [N_REQ];
   logic [ID_W-1:0] cand_idx [N_REQ];
   logic [ID_W-1:0] grant_id;
   logic            grant_any;
   logic            rsp_fire;
   logic [SW-1:0]   id_inc;
   logic [ID_W-1:0] rr_ptr_next;

   // cand_idx[k] is the requester examined k-th when searching from rr_ptr
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         logic [SW-1:0] sum;
         assign a_arr[gi]    = req_a[4*gi +: 4];
         assign b_arr[gi]    = req_b[4*gi +: 4];
         assign sum          = {1'b0, rr_ptr_reg} + SW'(gi);
         assign cand_idx[gi] = (sum >= N_L) ? ID_W'(sum - N_L) : sum[ID_W-1:0];
      end
   endgenerate

   always_comb begin
      grant_id  = '0;
      grant_any = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_valid[cand_idx[k]]) begin
            grant_id  = cand_idx[k];
            grant_any = 1'b1;
         end
      end
   end

   equality_comp u_cmp (
      .A        (op_a_reg),
      .B        (op_b_reg),
      .is_equal (is_equal)
   );

   assign rsp_fire    = rsp_valid & rsp_ready;
   assign id_inc      = {1'b0, rsp_id_reg} + SW'(1);
   assign rr_ptr_next = (id_inc >= N_L) ? '0 : id_inc[ID_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant_any) state_next = BUSY;
         BUSY:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Grant is gated by rst_n so no handshake can complete while reset is held
   always_comb begin
      req_ready = '0;
      rsp_valid = 1'b0;
      case (state_reg)
         IDLE:    if (grant_any && rst_n) req_ready[grant_id] = 1'b1;
         BUSY:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg <= '0;
         rsp_id_reg <= '0;
         op_a_reg   <= '0;
         op_b_reg   <= '0;
      end else begin
         if (state_reg == IDLE && grant_any) begin
            op_a_reg   <= a_arr[grant_id];
            op_b_reg   <= b_arr[grant_id];
            rsp_id_reg <= grant_id;
         end
         if (rsp_fire) begin
            rr_ptr_reg <= rr_ptr_next;
         end
      end
   end

   assign rsp_id    = rsp_id_reg;
   assign rsp_equal = rsp_valid & is_equal;

`ifdef EQ_HIT_COUNT_EN
   logic [CNT_W-1:0] hit_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_reg <= '0;
      end else if (rsp_fire && rsp_equal && (hit_cnt_reg != '1)) begin
         hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
      end
   end

   assign hit_cnt = hit_cnt_reg;
`endif

endmodule

// File: tb/tb_eq_compare_arbiter.sv
// Directed bench for eq_compare_arbiter with two requesters; hit counter checks
// are built only when EQ_HIT_COUNT_EN is defined.

module tb_eq_compare_arbiter;
   localparam int N_REQ = 2;
   localparam int ID_W  = 1;
   localparam int CNT_W = 2;

   logic              clk;
   logic              rst_n;
   logic [N_REQ-1:0]  req_valid;
   logic [4*N_REQ-1:0] req_a;
   logic [4*N_REQ-1:0] req_b;
   logic [N_REQ-1:0]  req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic              rsp_equal;
`ifdef EQ_HIT_COUNT_EN
   logic [CNT_W-1:0]  hit_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   eq_compare_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
`ifdef EQ_HIT_COUNT_EN
      .rsp_equal (rsp_equal),
      .hit_cnt   (hit_cnt)
`else
      .rsp_equal (rsp_equal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input int id);
      req_valid = N_REQ'(1 << id);
      rsp_ready = 1'b1;
      #1;
      step();
      req_valid = '0;
      step();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (2) step();

      // reset state
      req_valid = 2'b11;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_id",    32'(rsp_id),    32'h0);
      check("rst_rsp_equal", 32'(rsp_equal), 32'h0);
      req_valid = '0;
      rst_n     = 1'b1;
      step();

      // 1: single matching request
      req_a = 8'h05; req_b = 8'h05; rsp_ready = 1'b1; req_valid = 2'b01;
      #1;
      check("t1_req_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;
      #1;
      check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      check("t1_rsp_id",    32'(rsp_id),    32'h0);
      check("t1_rsp_equal", 32'(rsp_equal), 32'h1);
      check("t1_busy_ready", 32'(req_ready), 32'h0);
      step();
      check("t1_idle_valid", 32'(rsp_valid), 32'h0);

      // 2: mismatch with backpressure, requester 0 waits then withdraws
      req_a = 8'h40; req_b = 8'hE0; rsp_ready = 1'b0; req_valid = 2'b10;
      #1;
      check("t2_req_ready", 32'(req_ready), 32'h2);
      step();
      req_valid = 2'b01;
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_hold%0d_valid", i), 32'(rsp_valid), 32'h1);
         check($sformatf("t2_hold%0d_id", i),    32'(rsp_id),    32'h1);
         check($sformatf("t2_hold%0d_equal", i), 32'(rsp_equal), 32'h0);
         check($sformatf("t2_hold%0d_ready", i), 32'(req_ready), 32'h0);
         step();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      #1;
      step();
      check("t2_idle_valid", 32'(rsp_valid), 32'h0);
      check("t2_idle_ready", 32'(req_ready), 32'h0);

      // 3: contention, grants alternate starting from requester 0
      req_a = 8'h1D; req_b = 8'h0D; rsp_ready = 1'b1; req_valid = 2'b11;
      #1;
      for (int g = 0; g < 5; g++) begin
         check($sformatf("t3_g%0d_ready", g), 32'(req_ready), (g % 2 == 0) ? 32'h1 : 32'h2);
         step();
         check($sformatf("t3_g%0d_valid", g), 32'(rsp_valid), 32'h1);
         check($sformatf("t3_g%0d_id", g),    32'(rsp_id),    32'(g % 2));
         check($sformatf("t3_g%0d_equal", g), 32'(rsp_equal), (g % 2 == 0) ? 32'h1 : 32'h0);
         step();
      end
      check("t3_g5_ready", 32'(req_ready), 32'h2);
      step();
      check("t4_busy_id", 32'(rsp_id), 32'h1);

      // 4: reset while busy with requester 1
      rst_n = 1'b0;
      #1;
      check("t4_rst_valid", 32'(rsp_valid), 32'h0);
      check("t4_rst_ready", 32'(req_ready), 32'h0);
      step();
      rst_n = 1'b1;
      #1;
      check("t4_post_valid", 32'(rsp_valid), 32'h0);
      check("t4_post_ready", 32'(req_ready), 32'h1);

      // 5: requester 1 withdraws while requester 0 is being served
      req_valid = 2'b01; rsp_ready = 1'b0;
      #1;
      step();
      req_valid = 2'b10;
      #1;
      check("t5_busy_ready", 32'(req_ready), 32'h0);
      check("t5_busy_id",    32'(rsp_id),    32'h0);
      check("t5_busy_equal", 32'(rsp_equal), 32'h1);
      step();
      req_valid = '0;
      rsp_ready = 1'b1;
      #1;
      step();
      check("t5_idle_valid", 32'(rsp_valid), 32'h0);
      check("t5_idle_ready", 32'(req_ready), 32'h0);
      step();
      check("t5_no_rsp",     32'(rsp_valid), 32'h0);

`ifdef EQ_HIT_COUNT_EN
      // 6: saturating hit counter, requester 1 always mismatches
      rst_n = 1'b0;
      #1;
      check("t6_rst_hit", 32'(hit_cnt), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      begin
         int ids [6] = '{0, 0, 1, 0, 0, 0};
         int exps[6] = '{1, 2, 2, 3, 3, 3};
         for (int t = 0; t < 6; t++) begin
            txn(ids[t]);
            check($sformatf("t6_hit%0d_id%0d", t, ids[t]), 32'(hit_cnt), 32'(exps[t]));
         end
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
